// File: rtl/regfile_pkg.sv
// Shared definitions for the register file / scoreboard slice.
// RV32 defaults, the hardwired-zero register address, and the
// register-address type used by decode and writeback.
package regfile_pkg;

    localparam int RV_DATA_W = 32;
    localparam int RV_DEPTH  = 32;
    localparam int RV_ADDR_W = $clog2(RV_DEPTH);

    typedef logic [RV_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One read port of the register file.
// Selects a register from the flattened storage vector, forwards a write
// that targets the same address in the same cycle, forces register 0 to
// zero when it is hardwired, and optionally registers the result.
//   clock, resetN : clock and async active-low reset
//   rd_addr       : register address for this port
//   regs_flat     : all registers, register i at [i*DATA_W +: DATA_W]
//   wr_en/addr/data : the write port, used for bypass
//   rd_data       : read result (combinational or one cycle late)
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W       = RV_DATA_W,
    parameter int DEPTH        = RV_DEPTH,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int READ_LATENCY = 0,
    parameter int ZERO_REG     = 1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [DEPTH*DATA_W-1:0] regs_flat,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data
);

    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              is_zero;
    logic              bypass;

    always_comb begin
        is_zero   = (ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO));
        bypass    = wr_en && (wr_addr == rd_addr);
        rd_data_d = regs_flat[int'(rd_addr)*DATA_W +: DATA_W];
        if (bypass) begin
            rd_data_d = wr_data;
        end
        // Zero forcing last so a write to register 0 is never forwarded.
        if (is_zero) begin
            rd_data_d = '0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    // The output register is always built; with zero latency it is simply
    // unused and trimmed away.
    assign rd_data = (READ_LATENCY != 0) ? rd_data_q : rd_data_d;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with READ_PORTS read ports, one write port and a per-register
// busy scoreboard marking registers with a pending writeback.
//   clock, resetN            : clock and async active-low reset
//   regWrite/writeRegId/writeData : writeback port (also clears busy)
//   readReg / readData       : packed read addresses / data, port k in slice k
//   readBusy                 : busy bit of each addressed register
//   busySet / busySetId      : mark a register busy at issue
//   busyMask                 : full scoreboard vector
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W       = RV_DATA_W,
    parameter int DEPTH        = RV_DEPTH,
    parameter int READ_PORTS   = 2,
    parameter int READ_LATENCY = 0,
    parameter int ZERO_REG     = 1,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         regWrite,
    input  logic [ADDR_W-1:0]            writeRegId,
    input  logic [DATA_W-1:0]            writeData,
    input  logic [READ_PORTS*ADDR_W-1:0] readReg,
    output logic [READ_PORTS*DATA_W-1:0] readData,
    output logic [READ_PORTS-1:0]        readBusy,
    input  logic                         busySet,
    input  logic [ADDR_W-1:0]            busySetId,
    output logic [DEPTH-1:0]             busyMask
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0]       regs_q [DEPTH];
    logic [DATA_W-1:0]       regs_d [DEPTH];
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_d;
    logic [DEPTH*DATA_W-1:0] regs_flat;
    logic                    wr_en;

    always_comb begin
        wr_en = regWrite && !(ZERO_EN && (writeRegId == ADDR_W'(REG_ZERO)));
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[writeRegId] = writeData;
        end
    end

    // Clear first, set second: a new producer issued in the same cycle as
    // the old one's writeback keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (regWrite) begin
            busy_d[writeRegId] = 1'b0;
        end
        if (busySet) begin
            busy_d[busySetId] = 1'b1;
        end
        if (ZERO_EN) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign busyMask = busy_q;

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W       (DATA_W),
            .DEPTH        (DEPTH),
            .ADDR_W       (ADDR_W),
            .READ_LATENCY (READ_LATENCY),
            .ZERO_REG     (ZERO_REG)
        ) u_rd (
            .clock     (clock),
            .resetN    (resetN),
            .rd_addr   (readReg[k*ADDR_W +: ADDR_W]),
            .regs_flat (regs_flat),
            .wr_en     (regWrite),
            .wr_addr   (writeRegId),
            .wr_data   (writeData),
            .rd_data   (readData[k*DATA_W +: DATA_W])
        );

        // Post-edge state only; a same-cycle writeback does not hide busy.
        assign readBusy[k] = busy_q[readReg[k*ADDR_W +: ADDR_W]];
    end

endmodule
